// File: rtl/vc_test_src_arb_pkg.sv
// Shared types for the test-source round-robin arbiter.
// Holds the output-stage state encoding used by the top-level controller.
package vc_test_src_arb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    DRAINED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vc_rr_arb_pick.sv
// Combinational circular priority pick: one-hot grant to the first set req bit at or after ptr.
// Zero latency; grant is all-zero when no request is present.
module vc_rr_arb_pick #(
  parameter int p_nreqs = 2
) (
  input  logic [p_nreqs-1:0]         req,
  input  logic [$clog2(p_nreqs)-1:0] ptr,
  output logic [p_nreqs-1:0]         grant
);

  localparam int PW = $clog2(p_nreqs);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      idx = PW'((int'(ptr) + k) % p_nreqs);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_test_src_rr_arb.sv
// Round-robin merge of p_nreqs test sources into one registered output slot (1-cycle latency).
// in_rdy is offered only to the granted source while the slot is empty or draining this cycle.
module vc_test_src_rr_arb
  import vc_test_src_arb_pkg::*;
#(
  parameter int p_msg_nbits = 32,
  parameter int p_nreqs     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             in_val,
  output logic [p_nreqs-1:0]             in_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
  input  logic [p_nreqs-1:0]             in_done,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic [$clog2(p_nreqs)-1:0]     out_id,
  output logic                           done,
  output logic [31:0]                    num_msgs
);

  localparam int PW = $clog2(p_nreqs);

  arb_state_t             state, state_next;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          win_id;
  logic [p_msg_nbits-1:0] win_msg;
  logic [p_nreqs-1:0]     grant;
  logic                   can_accept;
  logic                   in_xfer;
  logic                   out_xfer;

  vc_rr_arb_pick #(
    .p_nreqs (p_nreqs)
  ) u_pick (
    .req   (in_val),
    .ptr   (ptr),
    .grant (grant)
  );

  assign out_val    = (state == FULL);
  assign out_xfer   = out_val && out_rdy;
  assign can_accept = !reset && ((state == EMPTY) || out_xfer);
  assign in_rdy     = can_accept ? grant : '0;
  assign in_xfer    = |(in_val & in_rdy);

  // Done is visible as soon as the slot is empty with every source finished, not only once DRAINED.
  assign done = !reset && ((state == DRAINED) ||
                           ((state == EMPTY) && (&in_done) && !in_xfer));

  always_comb begin
    win_id  = '0;
    win_msg = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      if (grant[i]) begin
        win_id  = PW'(i);
        win_msg = in_msg[i*p_msg_nbits +: p_msg_nbits];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (in_xfer)       state_next = FULL;
        else if (&in_done) state_next = DRAINED;
      end
      FULL: begin
        if (out_xfer && !in_xfer) state_next = EMPTY;
      end
      DRAINED: state_next = DRAINED;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      out_msg  <= '0;
      out_id   <= '0;
      num_msgs <= '0;
    end else begin
      if (in_xfer) begin
        out_msg <= win_msg;
        out_id  <= win_id;
        ptr     <= (win_id == PW'(p_nreqs - 1)) ? '0 : win_id + PW'(1);
      end
      if (out_xfer) num_msgs <= num_msgs + 32'd1;
    end
  end

endmodule

// File: doc/vc_test_src_rr_arb.md
VC_TEST_SRC_RR_ARB -- requirements
Module: vc_test_src_rr_arb

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 32: message width in bits.
REQ-002 SHALL have parameter p_nreqs, default 2, legal range 2..4: number of requesting test sources.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_val  input  p_nreqs: per-source valid, bit i = source i.
REQ-006 SHALL have port in_rdy  output  p_nreqs: per-source ready, bit i = source i.
REQ-007 SHALL have port in_msg  input  p_nreqs*p_msg_nbits: source i message in bits [i*p_msg_nbits +: p_msg_nbits].
REQ-008 SHALL have port in_done  input  p_nreqs: per-source all-messages-issued flag.
REQ-009 SHALL have port out_val  output  1: output stage holds a message.
REQ-010 SHALL have port out_rdy  input  1: sink accepts the message.
REQ-011 SHALL have port out_msg  output  p_msg_nbits: forwarded message.
REQ-012 SHALL have port out_id  output  $clog2(p_nreqs): index of the source the message came from.
REQ-013 SHALL have port done  output  1: all sources done and output stage drained.
REQ-014 SHALL have port num_msgs  output  32: count of messages delivered to the sink.

Function
REQ-015 Transfers on either side SHALL occur only in a cycle with val and rdy both high.
REQ-016 Output stage SHALL be a single registered entry; in-to-out latency SHALL be exactly 1 cycle, with no combinational path from in_msg to out_msg.
REQ-017 Output stage SHALL be able to accept a message when empty, or when full with out_rdy high in the same cycle (full-throughput pass-through, one message per cycle).
REQ-018 At most one in_rdy bit SHALL be high per cycle: the grant bit, and only while the output stage can accept.
REQ-019 The grant SHALL go to the first source with in_val high, searching circularly from priority pointer ptr; in_rdy SHALL NOT depend on in_val of non-granted sources beyond this search.
REQ-020 On a transfer from source w, ptr SHALL become (w+1) mod p_nreqs; with no transfer, ptr SHALL hold.
REQ-021 With no in_val high, all in_rdy SHALL be 0 and no state SHALL change except the output drain.
REQ-022 While the output stage is full and out_rdy is low, out_val, out_msg and out_id SHALL hold stable.
REQ-023 The state machine SHALL have states EMPTY, FULL and DRAINED:
  - EMPTY->FULL on an input transfer.
  - FULL->EMPTY on an output transfer without an input transfer.
  - FULL->FULL on no transfer, or on simultaneous input and output transfer.
  - EMPTY->DRAINED when all in_done bits are high and no input transfer occurs.
REQ-024 DRAINED SHALL be terminal until reset; in it done=1, out_val=0, all in_rdy=0.
REQ-025 num_msgs SHALL increment by 1 per output transfer and wrap from 2^32-1 to 0.
REQ-026 in_val from a source with in_done high SHALL still be served.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL enter EMPTY with ptr=0, out_val=0, out_msg=0, out_id=0, done=0, num_msgs=0.
REQ-028 All in_rdy outputs SHALL be 0 while reset is high.
REQ-029 Reset asserted mid-operation SHALL discard any held message without delivering it or counting it.

Structure
REQ-030 The state enum (EMPTY, FULL, DRAINED) SHALL be defined in shared package vc_test_src_arb_pkg.
REQ-031 The circular priority search SHALL be a sub-module vc_rr_arb_pick: combinational, with inputs req and ptr and output one-hot grant.
REQ-032 The output register, ptr, counter and state machine SHALL reside in the top module.

Verification
REQ-033 Bench SHALL cover: p_nreqs=2, both sources valid every cycle, out_rdy=1, msgs A0..A3 / B0..B3 -> out order A0,B0,A1,B1,...; out_id alternates 0,1; num_msgs=8.
REQ-034 Bench SHALL cover: only source 1 valid with 3 msgs -> delivered back-to-back 1 cycle after each accept; ptr settles at 0.
REQ-035 Bench SHALL cover: output full with out_rdy=0 for 5 cycles -> out_msg/out_id unchanged, all in_rdy=0; then out_rdy=1 -> delivery plus a new accept in the same cycle.
REQ-036 Bench SHALL cover: all in_done=1 after last accept -> done rises the cycle after the final output transfer and stays high.
REQ-037 Bench SHALL cover: reset pulsed while FULL -> out_val=0, num_msgs=0, held message never appears at the output.
REQ-038 Bench SHALL cover: the block driven by two random-delay test sources (max_delay 0 and 3) into a random-delay sink -> all messages delivered once, per-source order preserved.
